hex_scan_controller: RTL and testbench

//  Time-multiplexes NUM_DIGITS 4-bit values through one shared hex_decoder onto a

---
 rtl/hex_scan_pkg.sv | 18 +
 rtl/hex_decoder.sv | 37 +++
 rtl/hex_scan_controller.sv | 147 ++++++++++++++
 tb/tb_hex_scan_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// ============================================================================
// hex_scan_pkg : shared types and constants for the hex scan controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hex_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/hex_decoder.sv
// ============================================================================
// hex_decoder : 4-bit value to active-low 7-segment pattern, [0]=a .. [6]=g
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_decoder (
    input  logic [3:0] c,
    output logic [6:0] display
);

    always_comb begin
        display = 7'h7F;
        case (c)
            4'h0: display = 7'h40;
            4'h1: display = 7'h79;
            4'h2: display = 7'h24;
            4'h3: display = 7'h30;
            4'h4: display = 7'h19;
            4'h5: display = 7'h12;
            4'h6: display = 7'h02;
            4'h7: display = 7'h78;
            4'h8: display = 7'h00;
            4'h9: display = 7'h10;
            4'hA: display = 7'h08;
            4'hB: display = 7'h03;
            4'hC: display = 7'h46;
            4'hD: display = 7'h21;
            4'hE: display = 7'h06;
            4'hF: display = 7'h0E;
            default: display = 7'h7F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hex_scan_controller.sv
// ============================================================================
// hex_scan_controller : multiplexed 7-segment scanner with tear-free word load
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_scan_controller
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL      = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    zero_suppress,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(DWELL);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] c_CNT_LAST   = CW'(DWELL - 1);
    localparam logic [CW-1:0] c_BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);
    localparam logic [IW-1:0] c_IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] c_IDX_ONE    = IW'(1);

    scan_state_t             r_state;
    scan_state_t             w_state_next;
    logic [CW-1:0]           r_slot_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_full;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig_en;

    logic                    w_slot_end;
    logic                    w_accept;
    logic                    w_commit;
    logic [3:0]              w_nibble;
    logic [6:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_lead_zero;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_suppress;
    logic [6:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_en_next;

    assign w_slot_end = (r_slot_cnt == c_CNT_LAST);
    assign frame_done = w_slot_end && (r_idx == c_IDX_LAST);
    assign load_ready = ~r_pend_full;
    assign w_accept   = load_valid && !r_pend_full;
    assign w_commit   = frame_done && r_pend_full;
    assign seg        = r_seg;
    assign dig_en     = r_dig_en;

    // Digit i is a leading zero when it and every more-significant nibble are 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
            assign w_lead_zero[gi] = ~|r_display[4*NUM_DIGITS-1:4*gi];
        end
    endgenerate

    always_comb begin
        w_nibble = 4'h0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_onehot[i] = (r_idx == IW'(i));
            if (r_idx == IW'(i)) begin
                w_nibble = r_display[4*i +: 4];
            end
        end
    end

    assign w_suppress = zero_suppress && (r_idx != '0) && w_lead_zero[r_idx];

    hex_decoder u_hex_decoder (
        .c       (w_nibble),
        .display (w_dec_seg)
    );

    always_comb begin
        w_state_next = r_state;
        w_seg_next   = SEG_BLANK;
        w_en_next    = '0;
        case (r_state)
            S_BLANK: begin
                if (r_slot_cnt == c_BLANK_LAST) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!w_suppress) begin
                    w_seg_next = w_dec_seg;
                    w_en_next  = w_onehot;
                end
                if (w_slot_end) begin
                    w_state_next = S_BLANK;
                end
            end
            default: w_state_next = S_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_BLANK;
            r_slot_cnt <= '0;
            r_idx      <= '0;
            r_seg      <= SEG_BLANK;
            r_dig_en   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_seg    <= w_seg_next;
            r_dig_en <= w_en_next;
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
            end else begin
                r_slot_cnt <= r_slot_cnt + c_CNT_ONE;
            end
        end
    end

    // Accept and commit are exclusive: accept needs an empty pending slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_display   <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else if (w_commit) begin
            r_display   <= r_pending;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pending   <= load_data;
            r_pend_full <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_controller.sv
// ============================================================================
// tb_hex_scan_controller : scoreboard bench for hex_scan_controller (4 digits)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_scan_controller;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BC = 2;
    localparam int FR = ND * DW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        zero_suppress = 1'b0;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;
    int          pos;
    logic [15:0] disp;
    logic [15:0] pend_q[$];
    logic [10:0] out_q[$];

    hex_scan_controller #(
        .NUM_DIGITS (ND),
        .DWELL      (DW),
        .BLANK_CYC  (BC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .zero_suppress (zero_suppress),
        .seg           (seg),
        .dig_en        (dig_en),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [10:0] ref_out(input int p, input logic [15:0] w, input logic zs);
        int          s;
        int          c;
        logic [15:0] hi;
        s  = p / DW;
        c  = p % DW;
        hi = w >> (4 * s);
        if (c < BC) return {7'h7F, 4'b0000};
        if (zs && s != 0 && hi == 16'h0) return {7'h7F, 4'b0000};
        return {ref_seg(hi[3:0]), 4'(1 << s)};
    endfunction

    task automatic model_reset();
        pos  = 0;
        disp = '0;
        pend_q.delete();
        out_q.delete();
        out_q.push_back({7'h7F, 4'b0000});
    endtask

    // One clock: compare what the DUT shows now, queue next expectation, drive, advance model.
    task automatic step(input logic v, input logic [15:0] d);
        logic [10:0] e;
        e = out_q.pop_front();
        checks++;
        if ({seg, dig_en} !== e) begin
            errors++;
            $display("FAIL outputs pos=%0d got seg=%h en=%b exp seg=%h en=%b", pos, seg, dig_en, e[10:4], e[3:0]);
        end
        checks++;
        if (frame_done !== (pos == FR - 1)) begin
            errors++;
            $display("FAIL frame_done pos=%0d got=%b exp=%b", pos, frame_done, (pos == FR - 1));
        end
        checks++;
        if (load_ready !== (pend_q.size() == 0)) begin
            errors++;
            $display("FAIL load_ready pos=%0d got=%b exp=%b", pos, load_ready, (pend_q.size() == 0));
        end
        out_q.push_back(ref_out(pos, disp, zero_suppress));
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        if (pos == FR - 1 && pend_q.size() != 0) disp = pend_q.pop_front();
        else if (v && pend_q.size() == 0) pend_q.push_back(d);
        pos = (pos + 1) % FR;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0);
    endtask

    task automatic goto_pos(input int p);
        for (int k = 0; k < FR && pos != p; k++) step(1'b0, 16'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F || dig_en !== 4'b0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got seg=%h en=%b rdy=%b fd=%b exp 7f/0000/1/0", seg, dig_en, load_ready, frame_done);
        end
        reset_n = 1'b1;
        model_reset();
        idle(FR);
    endtask

    task automatic test_scan_timing();
        int first = -1;
        int gap   = -1;
        for (int k = 0; k < 2 * FR + 2; k++) begin
            checks++;
            if ($countones(dig_en) > 1) begin
                errors++;
                $display("FAIL onehot got en=%b exp at most one bit", dig_en);
            end
            if (frame_done === 1'b1) begin
                if (first >= 0 && gap < 0) gap = k - first;
                if (first < 0) first = k;
            end
            step(1'b0, 16'h0);
        end
        checks++;
        if (gap != FR) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", gap, FR);
        end
    endtask

    task automatic test_load_1234();
        goto_pos(3);
        step(1'b1, 16'h1234);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop got=%b exp=0", load_ready);
        end
        goto_pos(0);
        goto_pos(3);
        checks++;
        if (seg !== 7'h19 || dig_en !== 4'b0001) begin
            errors++;
            $display("FAIL digit0_1234 got seg=%h en=%b exp seg=19 en=0001", seg, dig_en);
        end
        goto_pos(0);
    endtask

    task automatic test_zero_suppress();
        zero_suppress = 1'b1;
        goto_pos(0);
        step(1'b1, 16'h0050);
        goto_pos(0);
        goto_pos(3 * DW + 3);
        checks++;
        if (seg !== 7'h7F || dig_en !== 4'b0000) begin
            errors++;
            $display("FAIL zs_digit3_on got seg=%h en=%b exp seg=7f en=0000", seg, dig_en);
        end
        goto_pos(0);
        zero_suppress = 1'b0;
        goto_pos(3 * DW + 3);
        checks++;
        if (seg !== 7'h40 || dig_en !== 4'b1000) begin
            errors++;
            $display("FAIL zs_digit3_off got seg=%h en=%b exp seg=40 en=1000", seg, dig_en);
        end
        goto_pos(0);
    endtask

    task automatic test_hold_valid();
        goto_pos(5);
        step(1'b1, 16'hA5C3);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready got=%b exp=0", load_ready);
        end
        for (int k = 0; k < 2 * FR; k++) step(1'b1, 16'($urandom));
        idle(2 * FR);
    endtask

    task automatic test_all_zero();
        zero_suppress = 1'b1;
        goto_pos(0);
        step(1'b1, 16'h0000);
        goto_pos(0);
        goto_pos(3);
        checks++;
        if (seg !== 7'h40 || dig_en !== 4'b0001) begin
            errors++;
            $display("FAIL allzero_digit0 got seg=%h en=%b exp seg=40 en=0001", seg, dig_en);
        end
        goto_pos(DW + 3);
        checks++;
        if (seg !== 7'h7F || dig_en !== 4'b0000) begin
            errors++;
            $display("FAIL allzero_digit1 got seg=%h en=%b exp seg=7f en=0000", seg, dig_en);
        end
        goto_pos(0);
        zero_suppress = 1'b0;
    endtask

    task automatic test_reset_mid();
        goto_pos(0);
        step(1'b1, 16'h9876);
        goto_pos(0);
        goto_pos(DW + 4);
        step(1'b1, 16'hABCD);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h7F || dig_en !== 4'b0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got seg=%h en=%b rdy=%b fd=%b exp 7f/0000/1/0", seg, dig_en, load_ready, frame_done);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(2 * FR);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            goto_pos(0);
            zero_suppress = 1'($urandom);
            step(1'b1, 16'($urandom_range(0, 16'h0FFF)));
        end
        goto_pos(0);
        idle(FR + 1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_timing();
        test_load_1234();
        test_zero_suppress();
        test_hold_valid();
        test_all_zero();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
